// File: rtl/region_load_router.sv
// Routes a byte stream into 16-bit writes for a selected load region.
// Region entries supply base address, storage target and lane order.
module region_load_router #(
    parameter int NUM_REGIONS = 8,
    parameter int IDX_W       = 3,
    parameter int REGION_W    = 40
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REGIONS*REGION_W-1:0] region_cfg,
    input  logic                            load_start,
    input  logic [IDX_W-1:0]                load_region,
    input  logic                            load_end,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    output logic                            in_ready,
    output logic                            wr_req,
    input  logic                            wr_ack,
    output logic [3:0]                      wr_storage,
    output logic [31:0]                     wr_addr,
    output logic [15:0]                     wr_data,
    output logic [1:0]                      wr_be,
    output logic                            busy,
    output logic                            error,
    output logic [31:0]                     bytes_loaded
);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FLUSH, DRAIN} state_t;

    state_t              state_q, next_state;
    logic [REGION_W-1:0] sel_entry;
    logic                idx_ok, start_ok;
    logic [31:0]         base_q, offset_q;
    logic [3:0]          storage_q;
    logic                swap_q, have_byte_q, end_seen_q;
    logic [7:0]          first_byte_q, flush_byte;
    logic                accept, word_done;

    always_comb begin
        sel_entry = '0;
        idx_ok    = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (load_region == IDX_W'(i)) begin
                sel_entry = region_cfg[i*REGION_W +: REGION_W];
                idx_ok    = 1'b1;
            end
        end
    end

    assign start_ok   = idx_ok && (sel_entry[3:0] <= 4'd1) && (sel_entry[7:4] <= 4'd2);
    assign in_ready   = (state_q == COLLECT) || (state_q == DRAIN);
    assign busy       = (state_q != IDLE);
    assign accept     = in_valid && in_ready;
    assign word_done  = accept && have_byte_q && (state_q == COLLECT);
    assign flush_byte = have_byte_q ? first_byte_q : in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (load_start) next_state = start_ok ? COLLECT : DRAIN;
            COLLECT: begin
                if (word_done)     next_state = WRITE;
                else if (load_end) next_state = (have_byte_q || accept) ? FLUSH : IDLE;
            end
            WRITE:   if (wr_req && wr_ack) next_state = (end_seen_q || load_end) ? IDLE : COLLECT;
            FLUSH:   if (wr_req && wr_ack) next_state = IDLE;
            DRAIN:   if (load_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_req       <= 1'b0;
            wr_storage   <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_be        <= '0;
            error        <= 1'b0;
            bytes_loaded <= '0;
            base_q       <= '0;
            offset_q     <= '0;
            storage_q    <= '0;
            swap_q       <= 1'b0;
            have_byte_q  <= 1'b0;
            end_seen_q   <= 1'b0;
            first_byte_q <= '0;
        end else begin
            if (accept) bytes_loaded <= bytes_loaded + 32'd1;
            if (load_start && state_q != IDLE) error <= 1'b1;
            case (state_q)
                IDLE: if (load_start) begin
                    error        <= !start_ok;
                    bytes_loaded <= '0;
                    have_byte_q  <= 1'b0;
                    end_seen_q   <= 1'b0;
                    offset_q     <= '0;
                    if (start_ok) begin
                        base_q    <= sel_entry[39:8];
                        storage_q <= sel_entry[7:4];
                        swap_q    <= sel_entry[0];
                    end
                end
                COLLECT: begin
                    if (word_done) begin
                        have_byte_q <= 1'b0;
                        end_seen_q  <= load_end;
                        wr_req      <= 1'b1;
                        wr_be       <= 2'b11;
                        wr_data     <= swap_q ? {first_byte_q, in_data} : {in_data, first_byte_q};
                        wr_addr     <= base_q + offset_q;
                        wr_storage  <= storage_q;
                    end else if (load_end && (have_byte_q || accept)) begin
                        // A lone byte may arrive with load_end itself; it still gets flushed.
                        have_byte_q <= 1'b0;
                        wr_req      <= 1'b1;
                        wr_be       <= swap_q ? 2'b10 : 2'b01;
                        wr_data     <= swap_q ? {flush_byte, 8'h00} : {8'h00, flush_byte};
                        wr_addr     <= base_q + offset_q;
                        wr_storage  <= storage_q;
                    end else if (accept) begin
                        first_byte_q <= in_data;
                        have_byte_q  <= 1'b1;
                    end
                end
                WRITE, FLUSH: begin
                    if (load_end) end_seen_q <= 1'b1;
                    if (wr_req && wr_ack) begin
                        wr_req   <= 1'b0;
                        offset_q <= offset_q + 32'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_region_load_router.sv
// Randomized scoreboard bench for region_load_router: expected writes are
// derived from the byte list per load and checked by an independent monitor.
module tb_region_load_router;

    localparam int NR = 8;
    localparam int IW = 4;
    localparam int RW = 40;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NR*RW-1:0] region_cfg;
    logic           load_start, load_end, in_valid, in_ready;
    logic [IW-1:0]  load_region;
    logic [7:0]     in_data;
    logic           wr_req, wr_ack, busy, error;
    logic [3:0]     wr_storage;
    logic [31:0]    wr_addr, bytes_loaded;
    logic [15:0]    wr_data;
    logic [1:0]     wr_be;

    region_load_router #(.NUM_REGIONS(NR), .IDX_W(IW), .REGION_W(RW)) dut (
        .clk(clk), .reset_n(reset_n), .region_cfg(region_cfg),
        .load_start(load_start), .load_region(load_region), .load_end(load_end),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_storage(wr_storage),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy(busy), .error(error), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [3:0]  stor;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stim[$];
    logic [31:0] base_m[NR];
    logic [3:0]  stor_m[NR];
    logic [3:0]  enc_m[NR];
    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned stall_left = 0;
    bit          ack_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: bytes pair up in arrival order; address advances 2 per word.
    task automatic model_push(input int unsigned r);
        int unsigned n = stim.size();
        wr_t w;
        for (int unsigned k = 0; k + 1 < n; k += 2) begin
            w.addr = base_m[r] + 32'(k);
            w.data = (enc_m[r] == 4'd1) ? {stim[k], stim[k+1]} : {stim[k+1], stim[k]};
            w.be   = 2'b11;
            w.stor = stor_m[r];
            exp_q.push_back(w);
        end
        if (n % 2 == 1) begin
            w.addr = base_m[r] + 32'(n - 1);
            w.data = (enc_m[r] == 4'd1) ? {stim[n-1], 8'h00} : {8'h00, stim[n-1]};
            w.be   = (enc_m[r] == 4'd1) ? 2'b10 : 2'b01;
            w.stor = stor_m[r];
            exp_q.push_back(w);
        end
    endtask

    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wr_req && stall_left > 0) begin
                wr_ack = 1'b0;
                stall_left--;
            end else begin
                wr_ack = wr_req && ack_en && ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && wr_req) begin
                chk("in_ready_low_during_write", {63'd0, in_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_req", {63'd0, wr_req}, 64'd0);
                end else begin
                    chk("wr_addr", {32'd0, wr_addr}, {32'd0, exp_q[0].addr});
                    chk("wr_data", {48'd0, wr_data}, {48'd0, exp_q[0].data});
                    chk("wr_be", {62'd0, wr_be}, {62'd0, exp_q[0].be});
                    chk("wr_storage", {60'd0, wr_storage}, {60'd0, exp_q[0].stor});
                    if (wr_ack) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int unsigned c = 0;
        while (busy && c < 300) begin @(posedge clk); #1; c++; end
        if (busy) chk(nm, {63'd0, busy}, 64'd0);
    endtask

    task automatic pulse_start(input int unsigned r);
        load_start = 1'b1; load_region = IW'(r);
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        int unsigned c = 0;
        while (!in_ready && c < 50) begin @(posedge clk); #1; c++; end
        if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_data = b; load_end = with_end;
        @(posedge clk); #1;
        in_valid = 1'b0; load_end = 1'b0;
    endtask

    task automatic run_load(input int unsigned r, input int unsigned gap,
                            input bit end_with_last, input bit poke);
        int unsigned n = stim.size();
        bit ok_cfg = (r < NR) && (enc_m[r % NR] <= 4'd1) && (stor_m[r % NR] <= 4'd2);
        wait_idle("idle_before_start");
        if (ok_cfg) model_push(r);
        pulse_start(r);
        for (int unsigned k = 0; k < n; k++) begin
            send_byte(stim[k], end_with_last && (k == n - 1));
            if (poke && k == 0) pulse_start($urandom_range(0, 11));
        end
        if (!(end_with_last && n > 0)) begin
            repeat (gap) begin @(posedge clk); #1; end
            load_end = 1'b1;
            @(posedge clk); #1;
            load_end = 1'b0;
        end
        wait_idle("idle_after_load");
        chk("error_flag", {63'd0, error}, ok_cfg ? {63'd0, poke} : 64'd1);
        if (ok_cfg) chk("bytes_loaded", {32'd0, bytes_loaded}, 64'(n));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0;
        in_data = '0; load_region = '0;
        for (int i = 0; i < NR; i++) begin
            base_m[i] = $urandom; stor_m[i] = 4'($urandom_range(0, 2));
            enc_m[i] = 4'($urandom_range(0, 1));
        end
        base_m[1] = 32'h0090_0000; stor_m[1] = 4'd0; enc_m[1] = 4'd0;
        base_m[2] = 32'h3810_0000; stor_m[2] = 4'd1; enc_m[2] = 4'd1;
        base_m[3] = 32'hFFFF_FFFE; stor_m[3] = 4'd2; enc_m[3] = 4'd0;
        enc_m[4] = 4'd2;
        stor_m[5] = 4'd3; enc_m[5] = 4'd0;
        for (int i = 0; i < NR; i++) region_cfg[i*RW +: RW] = {base_m[i], stor_m[i], enc_m[i]};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_wr_req", {63'd0, wr_req}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_bytes", {32'd0, bytes_loaded}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        stim = '{8'h11, 8'h22, 8'h33, 8'h44};          run_load(1, 2, 1'b0, 1'b0);
        stim = '{8'hAA, 8'hBB, 8'hCC};                 run_load(2, 1, 1'b0, 1'b0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};          run_load(3, 0, 1'b1, 1'b0);
        stall_left = 10;
        stim = '{8'h5A, 8'hA5};                        run_load(1, 0, 1'b0, 1'b0);
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        run_load(9, 1, 1'b0, 1'b0);

        // Reset with a write outstanding: expectation discarded with the write.
        ack_en = 1'b0;
        stim = '{8'h77, 8'h88};
        model_push(1);
        pulse_start(1);
        send_byte(8'h77, 1'b0);
        pulse_start(2);
        send_byte(8'h88, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("wr_req_before_reset", {63'd0, wr_req}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_req", {63'd0, wr_req}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_error", {63'd0, error}, 64'd0);
        chk("mid_rst_bytes", {32'd0, bytes_loaded}, 64'd0);
        chk("mid_rst_addr", {32'd0, wr_addr}, 64'd0);
        chk("mid_rst_data", {48'd0, wr_data}, 64'd0);
        chk("mid_rst_be", {62'd0, wr_be}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1; ack_en = 1'b1;
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};          run_load(1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int unsigned r = $urandom_range(0, 11);
            int unsigned n = $urandom_range(0, 9);
            stim.delete();
            for (int unsigned k = 0; k < n; k++) stim.push_back(8'($urandom));
            run_load(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     (n >= 1) && ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
